// File: rtl/idc_host_if.sv
// rtl/idc_host_if.sv - IDC input/output handshake bundle between host and core
interface idc_host_if;
   logic       in_valid;
   logic [6:0] in_data;
   logic [3:0] op;
   logic       out_valid;
   logic [6:0] out_data;

   modport master (output in_valid, in_data, op, input out_valid, out_data);
   modport slave  (input in_valid, in_data, op, output out_valid, out_data);
endinterface

// File: rtl/idc_host.sv
// rtl/idc_host.sv - host driver: streams image/ops into the IDC and captures its 16-sample burst
module idc_host #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cfg_we,
   input  logic [6:0] cfg_addr,
   input  logic [6:0] cfg_wdata,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [1:0] status,
   input  logic [3:0] res_addr,
   output logic [6:0] res_data,
   idc_host_if.master idc
);
   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_t;

   localparam logic [9:0] TO = 10'(TIMEOUT);

   state_t     state, state_nx;
   logic [5:0] k, k_nx;
   logic [9:0] wcnt, wcnt_nx;
   logic [3:0] idx, idx_nx;
   logic [1:0] status_nx;
   logic       send_load;
   logic [5:0] send_sel;
   logic       res_we;

   logic [6:0] img [0:63];
   logic [3:0] ops [0:14];
   logic [6:0] res [0:15];

   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);
   assign res_data = res[res_addr];

   // Next-state logic; send_load/send_sel select the pixel presented on the next cycle
   always_comb begin
      state_nx  = state;
      k_nx      = k;
      wcnt_nx   = wcnt;
      idx_nx    = idx;
      status_nx = status;
      send_load = 1'b0;
      send_sel  = 6'd0;
      res_we    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx  = S_SEND;
               status_nx = 2'b00;
               idx_nx    = 4'd0;
               k_nx      = 6'd0;
               send_load = 1'b1;
            end
         end
         S_SEND: begin
            if (idc.out_valid) status_nx[1] = 1'b1;
            if (k == 6'd63) begin
               state_nx = S_WAIT;
               wcnt_nx  = 10'd0;
            end else begin
               k_nx      = k + 6'd1;
               send_load = 1'b1;
               send_sel  = k + 6'd1;
            end
         end
         S_WAIT: begin
            if (idc.out_valid) begin
               res_we   = 1'b1;
               idx_nx   = 4'd1;
               state_nx = S_RECV;
            end else if (wcnt + 10'd1 == TO) begin
               status_nx[0] = 1'b1;
               state_nx     = S_DONE;
            end else begin
               wcnt_nx = wcnt + 10'd1;
            end
         end
         S_RECV: begin
            if (idc.out_valid) begin
               res_we = 1'b1;
               if (idx == 4'd15) state_nx = S_DONE;
               else              idx_nx   = idx + 4'd1;
            end else begin
               status_nx[1] = 1'b1;
               state_nx     = S_DONE;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Control state and registered IDC-facing outputs (zero whenever not sending)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         k            <= 6'd0;
         wcnt         <= 10'd0;
         idx          <= 4'd0;
         status       <= 2'b00;
         idc.in_valid <= 1'b0;
         idc.in_data  <= 7'd0;
         idc.op       <= 4'd0;
      end else begin
         state        <= state_nx;
         k            <= k_nx;
         wcnt         <= wcnt_nx;
         idx          <= idx_nx;
         status       <= status_nx;
         idc.in_valid <= send_load;
         idc.in_data  <= send_load ? img[send_sel] : 7'd0;
         idc.op       <= (send_load && send_sel < 6'd15) ? ops[send_sel[3:0]] : 4'd0;
      end
   end

   // Image/op config writes (idle only) and result capture; reset clears every buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) img[i] <= 7'd0;
         for (int i = 0; i < 15; i++) ops[i] <= 4'd0;
         for (int i = 0; i < 16; i++) res[i] <= 7'd0;
      end else begin
         if (cfg_we && state == S_IDLE) begin
            if (!cfg_addr[6])
               img[cfg_addr[5:0]] <= cfg_wdata;
            else if (cfg_addr[5:4] == 2'b00 && cfg_addr[3:0] != 4'hF)
               ops[cfg_addr[3:0]] <= cfg_wdata[3:0];
         end
         if (res_we) res[idx] <= idc.out_data;
      end
   end
endmodule

// File: tb/tb_idc_host.sv
// tb/tb_idc_host.sv - self-checking bench for idc_host with a scripted IDC stub
module tb_idc_host;
   localparam int TO = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_we;
   logic [6:0] cfg_addr;
   logic [6:0] cfg_wdata;
   logic       start;
   logic       busy;
   logic       done;
   logic [1:0] status;
   logic [3:0] res_addr;
   logic [6:0] res_data;

   idc_host_if idc ();

   idc_host #(.TIMEOUT(TO)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_wdata(cfg_wdata),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .status   (status),
      .res_addr (res_addr),
      .res_data (res_data),
      .idc      (idc)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [6:0] m_img [64];
   logic [3:0] m_ops [15];
   logic [6:0] m_res [16];
   logic [6:0] vals [32];
   logic [3:0] op_list [15] = '{4'd5, 4'd5, 4'd6, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                                4'd7, 4'd8, 4'd8, 4'd0, 4'd1, 4'd2, 4'd3};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg_write(input logic [6:0] a, input logic [6:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk);
      cfg_we = 1'b0;
      if (a < 7'd64)       m_img[a[5:0]] = d;
      else if (a <= 7'd78) m_ops[a - 64] = d[3:0];
   endtask

   task automatic check_res(input string nm);
      for (int i = 0; i < 16; i++) begin
         res_addr = 4'(i);
         #1;
         check($sformatf("%s_res%0d", nm, i), 32'(res_data), 32'(m_res[i]));
      end
   endtask

   // One frame: stub raises out_valid on cycles first_c..first_c+nsamp-1 (cycle 1 = first send cycle)
   task automatic run_frame(input string nm, input int first_c, input int nsamp,
                            input int spur_c, input int inject_c, input bit seq);
      int         done_c = 0;
      int         exp_done;
      int         n;
      int         bad_stream = 0;
      int         bad_busy = 0;
      int         done_cnt = 0;
      logic [1:0] exp_st;
      logic [1:0] st_c1 = 2'b11;
      logic [1:0] st_end = 2'b11;
      for (int i = 0; i < 32; i++) vals[i] = seq ? 7'(i + 1) : 7'($urandom);
      exp_st = (spur_c >= 1 && spur_c <= 64) ? 2'b10 : 2'b00;
      if (nsamp == 0 || first_c >= 65 + TO) begin
         exp_st[0] = 1'b1;
         exp_done  = 65 + TO;
      end else begin
         n = (nsamp < 16) ? nsamp : 16;
         for (int i = 0; i < n; i++) m_res[i] = vals[i];
         if (nsamp >= 16) exp_done = first_c + 16;
         else begin
            exp_st[1] = 1'b1;
            exp_done  = first_c + nsamp + 1;
         end
      end
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 200 && (done_c == 0 || c <= done_c + 2); c++) begin
         logic       ev;
         logic [6:0] ed;
         logic [3:0] eo;
         logic       sv;
         @(negedge clk);
         start  = 1'b0;
         cfg_we = 1'b0;
         ev = (c <= 64);
         ed = ev ? m_img[c-1] : 7'd0;
         eo = (c <= 15) ? m_ops[c-1] : 4'd0;
         if ({idc.in_valid, idc.in_data, idc.op} !== {ev, ed, eo}) bad_stream++;
         if (c == 1) st_c1 = status;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_c == 0) done_c = c;
         end
         if (busy !== ((done_c == 0) || (c == done_c))) bad_busy++;
         st_end = status;
         if (c == inject_c) begin
            start = 1'b1; cfg_we = 1'b1; cfg_addr = 7'd0; cfg_wdata = 7'd7;
         end
         sv = (c >= first_c && c < first_c + nsamp);
         idc.out_valid = sv || (c == spur_c);
         idc.out_data  = sv ? vals[c - first_c] : ((c == spur_c) ? 7'($urandom) : 7'd0);
      end
      idc.out_valid = 1'b0;
      idc.out_data  = 7'd0;
      start = 1'b0;
      cfg_we = 1'b0;
      check($sformatf("%s_stream_bad_cycles", nm), 32'(bad_stream), 32'd0);
      check($sformatf("%s_busy_bad_cycles", nm), 32'(bad_busy), 32'd0);
      check($sformatf("%s_done_cycle", nm), 32'(done_c), 32'(exp_done));
      check($sformatf("%s_done_pulses", nm), 32'(done_cnt), 32'd1);
      check($sformatf("%s_status_cleared", nm), 32'(st_c1), 32'd0);
      check($sformatf("%s_status", nm), 32'(st_end), 32'(exp_st));
      check_res(nm);
   endtask

   task automatic reset_mid_frame();
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("pre_reset_in_valid", 32'(idc.in_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_reset_outputs", 32'({busy, done, status, idc.in_valid, idc.in_data, idc.op}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 64; i++) m_img[i] = 7'd0;
      for (int i = 0; i < 15; i++) m_ops[i] = 4'd0;
      for (int i = 0; i < 16; i++) m_res[i] = 7'd0;
   endtask

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 7'd0; cfg_wdata = 7'd0;
      start = 1'b0; res_addr = 4'd0;
      idc.out_valid = 1'b0; idc.out_data = 7'd0;
      for (int i = 0; i < 64; i++) m_img[i] = 7'd0;
      for (int i = 0; i < 15; i++) m_ops[i] = 4'd0;
      for (int i = 0; i < 16; i++) m_res[i] = 7'd0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({busy, done, status, idc.in_valid, idc.in_data, idc.op}), 32'd0);
      rst_n = 1'b1;
      check_res("reset");

      for (int i = 0; i < 64; i++) cfg_write(7'(i), 7'(i - 32));
      for (int i = 0; i < 15; i++) cfg_write(7'(64 + i), {3'($urandom), op_list[i]});
      cfg_write(7'd79, 7'($urandom));
      cfg_write(7'd127, 7'($urandom));

      run_frame("basic", 67, 17, 0, 0, 1'b0);
      run_frame("timeout", 0, 0, 0, 0, 1'b0);
      run_frame("partial", 65, 8, 0, 0, 1'b1);
      run_frame("inject", 66, 16, 0, 20, 1'b0);
      run_frame("spur", 65, 16, 40, 0, 1'b0);

      for (int f = 0; f < 4; f++) begin
         for (int w = 0; w < 6; w++) cfg_write(7'($urandom), 7'($urandom));
         run_frame($sformatf("rand%0d", f), 65 + int'($urandom_range(0, TO + 1)),
                   int'($urandom_range(0, 18)),
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 64)) : 0, 0, 1'b0);
      end

      reset_mid_frame();
      check_res("after_reset");
      run_frame("zeros", 65, 16, 0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
